// File: rtl/neuron_pkg.sv
// Shared types for the neuron potential array: sweep state encoding and the
// signed saturation helper used by the clamped adder.
package neuron_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_SPIKE,
        ST_DONE
    } state_t;

    // Widest supported DATA_W; the extra bit holds the unclamped sum.
    localparam int SAT_MAX_W = 32;

    typedef logic signed [SAT_MAX_W:0] sat_wide_t;

    function automatic sat_wide_t sat_hi(input int w);
        return sat_wide_t'((64'sd1 <<< (w - 1)) - 64'sd1);
    endfunction

    function automatic sat_wide_t sat_lo(input int w);
        return -sat_hi(w) - sat_wide_t'(1);
    endfunction

    function automatic sat_wide_t sat_clamp(input sat_wide_t sum, input int w);
        if (sum > sat_hi(w)) begin
            return sat_hi(w);
        end
        if (sum < sat_lo(w)) begin
            return sat_lo(w);
        end
        return sum;
    endfunction

endpackage

// File: rtl/sat_adder.sv
// Signed two's-complement adder that clamps to the DATA_W range instead of
// wrapping; shared by event accumulation and per-step leak.
module sat_adder
    import neuron_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum
);

    sat_wide_t a_ext;
    sat_wide_t b_ext;

    assign a_ext = sat_wide_t'($signed(a));
    assign b_ext = sat_wide_t'($signed(b));
    assign sum   = DATA_W'(sat_clamp(a_ext + b_ext, DATA_W));

endmodule

// File: rtl/neuron_potential_array.sv
// Array of leaky integrate-and-fire potentials: weight events accumulate while
// idle, a timestep sweep leaks every neuron and emits spikes. Optional macro
// REFRACTORY_EN adds per-neuron refractory counters.
module neuron_potential_array
    import neuron_pkg::*;
#(
    parameter int NUM_NEURONS  = 16,
    parameter int DATA_W       = 16,
    parameter int ID_W         = $clog2(NUM_NEURONS),
    parameter int DECAY_SHIFT  = 3,
    parameter int V_REST       = 0,
    parameter int REFRAC_STEPS = 2
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [DATA_W-1:0] v_threshold,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ID_W-1:0]   in_id,
    input  logic [DATA_W-1:0] in_weight,
    input  logic              step_start,
    output logic              step_busy,
    output logic              step_done,
    output logic              spike_valid,
    input  logic              spike_ready,
    output logic [ID_W-1:0]   spike_id,
    input  logic [ID_W-1:0]   rd_id,
    output logic [DATA_W-1:0] rd_potential
);

    localparam logic [DATA_W-1:0] REST_P  = DATA_W'(V_REST);
    localparam logic [ID_W-1:0]   LAST_ID = ID_W'(NUM_NEURONS - 1);

    // Leak negation relies on a non-zero shift; the refractory length must be positive.
    if (NUM_NEURONS < 2 || DATA_W > SAT_MAX_W || DECAY_SHIFT < 1 || REFRAC_STEPS < 1) begin : g_cfg_check
        $error("neuron_potential_array: unsupported parameter set");
    end

    state_t                  state;
    logic [DATA_W-1:0]       potential [NUM_NEURONS];
    logic [ID_W-1:0]         sweep_id;
    logic                    spike_valid_q;
    logic [ID_W-1:0]         spike_id_q;
    logic                    step_done_q;

    logic                    acc_in_range;
    logic [ID_W-1:0]         acc_id;
    logic                    acc_refrac;
    logic                    sweep_refrac;
    logic                    event_accept;
    logic                    fire;
    logic                    last_neuron;
    logic signed [DATA_W-1:0] leak;
    logic [DATA_W-1:0]       add_a;
    logic [DATA_W-1:0]       add_b;
    logic [DATA_W-1:0]       add_sum;

    assign acc_in_range = int'(in_id) < NUM_NEURONS;
    assign acc_id       = acc_in_range ? in_id : '0;
    assign last_neuron  = (sweep_id == LAST_ID);

    assign in_ready     = (state == ST_IDLE);
    assign step_busy    = (state != ST_IDLE);
    assign step_done    = step_done_q;
    assign spike_valid  = spike_valid_q;
    assign spike_id     = spike_id_q;
    assign rd_potential = (int'(rd_id) < NUM_NEURONS) ? potential[rd_id] : REST_P;

    // One adder serves both phases: idle accumulates the event, sweep subtracts the leak.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        leak  = $signed(potential[sweep_id]) >>> DECAY_SHIFT;
        add_a = potential[sweep_id];
        add_b = -leak;
        if (state == ST_IDLE) begin
            add_a = potential[acc_id];
            add_b = in_weight;
        end
    end

    sat_adder #(
        .DATA_W (DATA_W)
    ) u_sat_adder (
        .a   (add_a),
        .b   (add_b),
        .sum (add_sum)
    );

    assign event_accept = (state == ST_IDLE) && in_valid && acc_in_range && !acc_refrac;
    assign fire         = (state == ST_SWEEP) && !sweep_refrac
                          && ($signed(add_sum) >= $signed(v_threshold));

`ifdef REFRACTORY_EN
    localparam int RC_W = $clog2(REFRAC_STEPS + 1);

    logic [RC_W-1:0] refrac_cnt [NUM_NEURONS];

    assign acc_refrac   = (refrac_cnt[acc_id] != '0);
    assign sweep_refrac = (refrac_cnt[sweep_id] != '0);

    // Counters tick once per sweep visit, so refractory length is counted in timesteps.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                refrac_cnt[i] <= '0;
            end
        end else if (state == ST_SWEEP) begin
            if (fire) begin
                refrac_cnt[sweep_id] <= RC_W'(REFRAC_STEPS);
            end else if (sweep_refrac) begin
                refrac_cnt[sweep_id] <= refrac_cnt[sweep_id] - RC_W'(1);
            end
        end
    end
`else
    assign acc_refrac   = 1'b0;
    assign sweep_refrac = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= ST_IDLE;
            sweep_id      <= '0;
            spike_valid_q <= 1'b0;
            spike_id_q    <= '0;
            step_done_q   <= 1'b0;
            // NOTE: the potential array lives in flops, not RAM, so it can be cleared in reset.
            for (int i = 0; i < NUM_NEURONS; i++) begin
                potential[i] <= REST_P;
            end
        end else begin
            // NOTE: non-blocking assignments keep every read in this block on pre-edge values.
            step_done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (event_accept) begin
                        potential[acc_id] <= add_sum;
                    end
                    if (step_start) begin
                        state    <= ST_SWEEP;
                        sweep_id <= '0;
                    end
                end
                ST_SWEEP: begin
                    if (fire) begin
                        potential[sweep_id] <= REST_P;
                        spike_valid_q       <= 1'b1;
                        spike_id_q          <= sweep_id;
                        state               <= ST_SPIKE;
                    end else begin
                        potential[sweep_id] <= add_sum;
                        if (last_neuron) begin
                            state       <= ST_DONE;
                            step_done_q <= 1'b1;
                        end else begin
                            sweep_id <= sweep_id + ID_W'(1);
                        end
                    end
                end
                ST_SPIKE: begin
                    if (spike_ready) begin
                        spike_valid_q <= 1'b0;
                        if (last_neuron) begin
                            state       <= ST_DONE;
                            step_done_q <= 1'b1;
                        end else begin
                            sweep_id <= sweep_id + ID_W'(1);
                            state    <= ST_SWEEP;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/neuron_potential_array.md
NEURON_POTENTIAL_ARRAY -- requirements
Module: neuron_potential_array

Interface
REQ-001 Parameter NUM_NEURONS, default 16, number of neurons held in the array.
REQ-002 Parameter DATA_W, default 16, signed two's-complement potential, weight and threshold width.
REQ-003 Parameter ID_W, default $clog2(NUM_NEURONS), neuron index width.
REQ-004 Parameter DECAY_SHIFT, default 3, leak per step: p - (p >>> DECAY_SHIFT).
REQ-005 Parameter V_REST, default 0, post-spike reset potential.
REQ-006 Parameter REFRAC_STEPS, default 2, refractory length in timesteps (used only under REFRACTORY_EN).
REQ-007 One clock; reset is asynchronous and active-low.
REQ-008 Ports: CLK in 1 clock; RESET_N in 1 async active-low reset; v_threshold in DATA_W firing threshold; in_valid in 1 weight event valid; in_ready out 1 weight event accepted; in_id in ID_W target neuron; in_weight in DATA_W signed weight; step_start in 1 timestep request; step_busy out 1 sweep in progress; step_done out 1 one-cycle pulse at sweep end; spike_valid out 1 spike presented; spike_ready in 1 spike consumed; spike_id out ID_W spiking neuron; rd_id in ID_W debug index; rd_potential out DATA_W combinational potential[rd_id].

Function
REQ-009 States IDLE, SWEEP, SPIKE, DONE; IDLE->SWEEP on step_start, SWEEP->SPIKE on threshold crossing, SPIKE->SWEEP on spike handshake (or ->DONE if last neuron), SWEEP->DONE after neuron NUM_NEURONS-1, DONE->IDLE unconditionally.
REQ-010 in_ready SHALL be 1 only in IDLE; step_busy SHALL be 1 in SWEEP, SPIKE, DONE.
REQ-011 Accepted event (in_valid && in_ready) SHALL update potential[in_id] <= sat(potential[in_id] + in_weight) at that edge; latency 1 cycle to rd_potential.
REQ-012 Saturation SHALL clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; no wrap-around.
REQ-013 Event with in_id >= NUM_NEURONS SHALL be accepted and discarded.
REQ-014 in_valid and step_start together in IDLE: event applied at that edge, sweep begins next cycle and sees the updated value.
REQ-015 step_start outside IDLE SHALL be ignored (no queuing).
REQ-016 SWEEP processes one neuron per cycle, index 0 upward: d = p - (p >>> DECAY_SHIFT); if d >= v_threshold (signed) potential <= V_REST and enter SPIKE, else potential <= d.
REQ-017 In SPIKE, spike_valid=1 and spike_id stable until spike_ready=1; transfer completes on the edge with both high.
REQ-018 No-spike sweep: step_done pulses exactly NUM_NEURONS+1 cycles after the step_start edge; each spike adds >=1 cycle.
REQ-019 v_threshold SHALL be sampled per neuron in its SWEEP cycle.

Reset
REQ-020 RESET_N low SHALL immediately force IDLE, all potentials to V_REST, spike_valid=0, step_done=0, step_busy=0, in_ready=1 after release; mid-sweep reset abandons the sweep with no pending spike.

Configuration
REQ-021 Macro REFRACTORY_EN defined: per-neuron counter loaded with REFRAC_STEPS on spike, decremented each sweep visit; while non-zero, accepted events to that neuron are discarded and it cannot spike (decay still applies).
REQ-022 REFRACTORY_EN undefined: no counters exist; every event and crossing acts normally.

Structure
REQ-023 Package neuron_pkg SHALL hold the state enum and the saturating-add function/limits.
REQ-024 One sub-module sat_adder (DATA_W parameter) SHALL implement the clamped signed add shared by accumulate and decay.

Verification (DATA_W=16, NUM_NEURONS=16, DECAY_SHIFT=3, v_threshold=100)
REQ-025 Reset mid-SWEEP -> all rd_potential=0, spike_valid=0, in_ready=1 on release.
REQ-026 Weights 40,40,40 to id 3, step -> spike_id=3 (d=105), potential[3]=0, step_done at cycle 18 if spike_ready held 1.
REQ-027 Weight 80 to id 7, step -> no spike, potential[7]=70, step_done exactly 17 cycles after start.
REQ-028 Weights 0x7FFF twice to id 0 -> 0x7FFF; 0x8000 twice to id 1 -> 0x8000.
REQ-029 Crossings on ids 1 and 5, spike_ready low 4 cycles -> spike_valid/spike_id=1 held stable, then id 5, then step_done.
REQ-030 REFRACTORY_EN: id 2 spikes, weight 200 in each of next 2 steps ignored, third step's 200 -> spike.
